// File: rtl/inst_pipe_reg.sv
// inst_pipe_reg
//   Two-entry instruction pipeline register (main + skid). The main entry
//   drives the outputs. The skid entry catches a word that arrives while
//   main is stalled. in_ready is registered, so there is no combinational
//   path from out_ready back to upstream.
//
// Parameters
//   WIDTH     instruction word width
//   NOP       value presented on out_inst while out_valid=0
//   PC_WIDTH  PC sideband width (only meaningful with INST_PIPE_REG_PC_EN)
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   flush      discard all held entries at the next edge
//   in_valid   upstream offers in_inst
//   in_ready   stage can accept a word this cycle (skid entry empty)
//   in_inst    incoming instruction
//   out_valid  out_inst holds a valid entry
//   out_ready  downstream consumes this cycle
//   out_inst   presented instruction (NOP when out_valid=0)
//   pc_in      PC captured with in_inst     (INST_PIPE_REG_PC_EN only)
//   pc_out     PC of presented instruction  (INST_PIPE_REG_PC_EN only)
//
// Configuration macro
//   INST_PIPE_REG_PC_EN  adds the pc_in/pc_out sideband and its storage.
module inst_pipe_reg #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] NOP      = {WIDTH{1'b0}},
  parameter int               PC_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_inst
`ifdef INST_PIPE_REG_PC_EN
  ,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic [PC_WIDTH-1:0] pc_out
`endif
);

  // The PC travels as the upper bits of a single payload word, so it
  // follows its instruction through main/skid with no extra control.
`ifdef INST_PIPE_REG_PC_EN
  localparam int PW = WIDTH + PC_WIDTH;
`else
  // PC_WIDTH contributes no storage in this build.
  localparam int PW = WIDTH + 0 * PC_WIDTH;
`endif

  logic [PW-1:0] in_data;
  logic [PW-1:0] main_data;
  logic [PW-1:0] skid_data;
  logic          main_valid;
  logic          skid_valid;
  logic          ready_q;
  logic          accept;
  logic          pop;

`ifdef INST_PIPE_REG_PC_EN
  assign in_data = {pc_in, in_inst};
`else
  assign in_data = in_inst;
`endif

  assign accept = in_valid & ready_q;
  assign pop    = main_valid & out_ready;

  // Invariant: skid_valid implies main_valid. When main is free (empty or
  // popping), skid drains into it first and a new word goes behind it;
  // otherwise a new word can only land in skid, which accept guarantees
  // is empty. ready_q tracks the next skid state so in_ready is a flop.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (pop || !main_valid) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= accept;
        ready_q    <= ~accept;
        if (accept) begin
          skid_data <= in_data;
        end
      end else begin
        main_valid <= accept;
        ready_q    <= 1'b1;
        if (accept) begin
          main_data <= in_data;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      ready_q    <= 1'b0;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_inst  = main_valid ? main_data[WIDTH-1:0] : NOP;

`ifdef INST_PIPE_REG_PC_EN
  assign pc_out = main_valid ? main_data[PW-1:WIDTH] : {PC_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_inst_pipe_reg.sv
// tb_inst_pipe_reg
//   Self-checking bench for inst_pipe_reg (default build, WIDTH=32).
//   The reference is a FIFO queue of at most two words: in_ready means
//   fewer than two held, out_valid means non-empty, out_inst is the head.
module tb_inst_pipe_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_q[$];

  inst_pipe_reg #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Compare every output against the queue model.
  task automatic compare_all(input string tag);
    logic [31:0] exp_inst;
    exp_inst = (model_q.size() > 0) ? model_q[0] : 32'h0;
    check_output({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, model_q.size() > 0});
    check_output({tag, ".out_inst"}, out_inst, exp_inst);
    check_output({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, model_q.size() < 2});
  endtask

  // Drive one cycle of inputs (inputs change on the falling edge), update
  // the model at the rising edge, then check on the next falling edge.
  task automatic apply_stimulus(input logic rst_n, input logic fl, input logic iv,
                                input logic [31:0] data, input logic ordy,
                                input string tag);
    bit acc;
    bit pp;
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_inst   = data;
    out_ready = ordy;
    acc = iv && (model_q.size() < 2);
    pp  = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (!rst_n || fl) begin
      model_q.delete();
    end else begin
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back(data);
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, "reset");
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "reset2");

    // Single word passes through with one cycle latency
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h00A00093, 1'b1, "single_in");
    check_output("single_direct", out_inst, 32'h00A00093);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "single_out");
    check_output("single_empty", out_inst, 32'h0);

    // Fill both entries under stall; third word refused
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, "fill1");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, "fill2");
    check_output("full_ready", {31'b0, in_ready}, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0, "refuse3");
    check_output("held_inst", out_inst, 32'h11111111);

    // Drain in order while the third word stays offered
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1, "drain1");
    check_output("drain1_direct", out_inst, 32'h22222222);
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1, "drain2");
    check_output("drain2_direct", out_inst, 32'h33333333);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "drain3");

    // Flush with two held and a word offered
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'hA0000001, 1'b0, "pre_flush1");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'hA0000002, 1'b0, "pre_flush2");
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, "flush");
    check_output("flush_valid", {31'b0, out_valid}, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "post_flush");

    // Reset beats flush and pop with two held
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'hB0000001, 1'b0, "pre_rst1");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'hB0000002, 1'b0, "pre_rst2");
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hB0000003, 1'b1, "mid_reset");
    check_output("mid_reset_ready", {31'b0, in_ready}, 32'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "post_reset");

    // Randomized traffic against the queue model
    for (int i = 0; i < 1500; i++) begin
      logic r_n, fl, iv, ordy;
      r_n  = ($urandom_range(0, 63) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      iv   = ($urandom_range(0, 99) < 65);
      ordy = ($urandom_range(0, 99) < 55);
      apply_stimulus(r_n, fl, iv, $urandom, ordy, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
